// File: rtl/mix_columns.sv
// ============================================================================
//  Module      : mix_columns
//  Description : AES MixColumns / InvMixColumns over the full 128-bit state,
//                all four columns in parallel, registered output with valid.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mix_columns (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic         inv,
   input  logic [127:0] IN,
   output logic [127:0] OUT,
   output logic         out_valid
);

   // Multiply by x in GF(2^8), reducing by 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul2(input logic [7:0] x);
      return xtime(x);
   endfunction

   function automatic logic [7:0] mul3(input logic [7:0] x);
      return xtime(x) ^ x;
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] x);
      logic [7:0] x2, x4, x8;
      x2 = xtime(x);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x;
   endfunction

   function automatic logic [7:0] mulb(input logic [7:0] x);
      logic [7:0] x2, x4, x8;
      x2 = xtime(x);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x2 ^ x;
   endfunction

   function automatic logic [7:0] muld(input logic [7:0] x);
      logic [7:0] x2, x4, x8;
      x2 = xtime(x);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ x;
   endfunction

   function automatic logic [7:0] mule(input logic [7:0] x);
      logic [7:0] x2, x4, x8;
      x2 = xtime(x);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction

   // Column layout: row 0 in the top byte.
   function automatic logic [31:0] fwd_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      b0 = mul2(a0) ^ mul3(a1) ^ a2       ^ a3;
      b1 = a0       ^ mul2(a1) ^ mul3(a2) ^ a3;
      b2 = a0       ^ a1       ^ mul2(a2) ^ mul3(a3);
      b3 = mul3(a0) ^ a1       ^ a2       ^ mul2(a3);
      return {b0, b1, b2, b3};
   endfunction

   function automatic logic [31:0] inv_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      b0 = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
      b1 = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
      b2 = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
      b3 = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
      return {b0, b1, b2, b3};
   endfunction

   logic [127:0] next_state;

   // Column 0 occupies IN[127:96].
   genvar c;
   generate
      for (c = 0; c < 4; c++) begin : g_col
         logic [31:0] col_in;
         logic [31:0] col_fwd;
         logic [31:0] col_inv;

         assign col_in  = IN[127 - 32*c -: 32];
         assign col_fwd = fwd_column(col_in);
         assign col_inv = inv_column(col_in);
         assign next_state[127 - 32*c -: 32] = inv ? col_inv : col_fwd;
      end
   endgenerate

   logic [127:0] out_q;
   logic         valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= 128'h0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            out_q <= next_state;
         end
      end
   end

   assign OUT       = out_q;
   assign out_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mix_columns.sv
// ============================================================================
//  Module      : tb_mix_columns
//  Description : Directed and randomized self-checking bench for mix_columns.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mix_columns;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         inv;
   logic [127:0] IN;
   logic [127:0] OUT;
   logic         out_valid;

   int checks = 0;
   int errors = 0;

   mix_columns dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .inv       (inv),
      .IN        (IN),
      .OUT       (OUT),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Generic shift-and-add GF(2^8) multiply used as the reference.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int k = 0; k < 8; k++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] ref_model(input logic [127:0] s, input logic mode);
      logic [7:0]   coef [4];
      logic [7:0]   a    [4];
      logic [7:0]   b;
      logic [127:0] r;
      if (mode) begin
         coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
      end else begin
         coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
      end
      r = '0;
      for (int col = 0; col < 4; col++) begin
         for (int row = 0; row < 4; row++)
            a[row] = s[127 - 8*(4*col + row) -: 8];
         for (int row = 0; row < 4; row++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++)
               b = b ^ gmul(coef[(j - row + 4) % 4], a[j]);
            r[127 - 8*(4*col + row) -: 8] = b;
         end
      end
      return r;
   endfunction

   task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [127:0] x;
   logic [127:0] fx;
   logic         m;

   initial begin
      rst      = 1'b1;
      in_valid = 1'b1;
      inv      = 1'b0;
      IN       = 128'hdeadbeef_01234567_89abcdef_cafef00d;

      // Reset dominates a simultaneous transaction.
      step();
      check128("reset_out_0", OUT, 128'h0);
      check1  ("reset_vld_0", out_valid, 1'b0);
      step();
      check128("reset_out_1", OUT, 128'h0);
      check1  ("reset_vld_1", out_valid, 1'b0);
      rst      = 1'b0;
      in_valid = 1'b0;
      step();
      check128("idle_out", OUT, 128'h0);
      check1  ("idle_vld", out_valid, 1'b0);

      // FIPS-197 forward vector, single pulse.
      in_valid = 1'b1;
      inv      = 1'b0;
      IN       = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
      step();
      in_valid = 1'b0;
      check128("fips_fwd", OUT, 128'h046681e5e0cb199a48f8d37a2806264c);
      check1  ("fips_fwd_vld", out_valid, 1'b1);
      step();
      check1  ("fips_fwd_vld_drop", out_valid, 1'b0);
      check128("fips_fwd_hold", OUT, 128'h046681e5e0cb199a48f8d37a2806264c);

      // Known columns.
      in_valid = 1'b1;
      IN       = 128'hdb135345f20a225c01010101c6c6c6c6;
      step();
      check128("known_fwd", OUT, 128'h8e4da1bc9fdc589d01010101c6c6c6c6);
      IN       = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
      step();
      check128("col_fwd", OUT, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff);

      // Inverse mode.
      inv      = 1'b1;
      IN       = 128'h046681e5e0cb199a48f8d37a2806264c;
      step();
      check128("fips_inv", OUT, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
      IN       = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
      step();
      check128("known_inv", OUT, 128'hdb135345f20a225c01010101c6c6c6c6);

      // Streaming with inv toggling every cycle.
      inv      = 1'b0;
      IN       = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
      step();
      check128("stream_0", OUT, 128'h046681e5e0cb199a48f8d37a2806264c);
      check1  ("stream_vld_0", out_valid, 1'b1);
      inv      = 1'b1;
      IN       = 128'h046681e5e0cb199a48f8d37a2806264c;
      step();
      check128("stream_1", OUT, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
      check1  ("stream_vld_1", out_valid, 1'b1);
      inv      = 1'b0;
      IN       = 128'hdb135345f20a225c01010101c6c6c6c6;
      step();
      check128("stream_2", OUT, 128'h8e4da1bc9fdc589d01010101c6c6c6c6);
      check1  ("stream_vld_2", out_valid, 1'b1);
      inv      = 1'b1;
      IN       = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
      step();
      check128("stream_3", OUT, 128'hdb135345f20a225c01010101c6c6c6c6);
      check1  ("stream_vld_3", out_valid, 1'b1);
      in_valid = 1'b0;
      IN       = 128'hffffffffffffffffffffffffffffffff;
      inv      = 1'b0;
      step();
      check128("stream_hold", OUT, 128'hdb135345f20a225c01010101c6c6c6c6);
      check1  ("stream_vld_drop", out_valid, 1'b0);

      // Random states against the reference model, plus inverse round-trip.
      for (int i = 0; i < 300; i++) begin
         x        = {$urandom, $urandom, $urandom, $urandom};
         m        = 1'($urandom_range(0, 1));
         in_valid = 1'b1;
         inv      = m;
         IN       = x;
         step();
         check128("random", OUT, ref_model(x, m));
         check1  ("random_vld", out_valid, 1'b1);
         fx       = ref_model(x, 1'b0);
         inv      = 1'b1;
         IN       = fx;
         step();
         check128("roundtrip", OUT, x);
      end

      // Reset mid-stream clears on the next edge.
      in_valid = 1'b1;
      inv      = 1'b0;
      IN       = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
      step();
      check128("pre_reset", OUT, 128'h046681e5e0cb199a48f8d37a2806264c);
      rst      = 1'b1;
      step();
      check128("mid_reset_out", OUT, 128'h0);
      check1  ("mid_reset_vld", out_valid, 1'b0);
      rst      = 1'b0;
      in_valid = 1'b0;
      step();
      check128("post_reset_out", OUT, 128'h0);
      check1  ("post_reset_vld", out_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
